vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
Single-port video RAM access scheduler that shares one synchronous RAM between the tile/pixel fetch path and the CPU. Video fetch has absolute priority so scanout never stalls. CPU writes are posted through a one-entry write buffer; CPU reads are serviced in free slots. CPU access during active display is configurable. The `blank` input comes from the VGA timing block.

Parameters:
AW, 12, VRAM address width
DW, 8, VRAM data width
ACTIVE_CPU, 1, 1 = CPU may use idle slots during active display; 0 = CPU served only while blank=1
SW, 16, stall counter width

Ports:
clk  input  1  system clock (100 MHz domain)
reset  input  1  synchronous, active-high
blank  input  1  1 outside visible area, from VGA timing
vid_req  input  1  video read request, one cycle per access
vid_addr  input  AW  video read address
vid_rvalid  output  1  video read data valid
vid_rdata  output  DW  video read data
cpu_req  input  1  CPU request; held with cpu_we, cpu_addr, cpu_wdata stable until cpu_ack
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_ack  output  1  request accepted this cycle (combinational)
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  DW  CPU read data
mem_addr  output  AW  RAM address (combinational)
mem_we  output  1  RAM write enable (combinational)
mem_wdata  output  DW  RAM write data
mem_rdata  input  DW  RAM read data, valid one cycle after address
wbuf_full  output  1  posted write pending
stall_clr  input  1  clears stall counter
cpu_stall_cnt  output  SW  count of cycles with cpu_req=1 and cpu_ack=0

Behaviour:
- Clock, reset, and slot rule:
  - One clock, clk. Reset is synchronous and active-high.
  - One RAM slot per cycle.
  - cpu_ok = blank | ACTIVE_CPU.
- Slot priority, highest first:
  1. vid_req=1: video read. mem_addr=vid_addr, mem_we=0. Never refused.
  2. wbuf_full=1 & cpu_ok: drain the buffer. mem_addr/mem_wdata come from the buffer, mem_we=1.
  3. cpu_req=1 & cpu_we=0 & wbuf_full=0 & cpu_ok: CPU read. mem_addr=cpu_addr, cpu_ack=1.
  4. Otherwise idle: mem_we=0, mem_addr=0, mem_wdata=0.
- CPU write acceptance:
  - cpu_ack=1 in the same cycle when cpu_req=1 & cpu_we=1 & (wbuf_full=0 | buffer draining this cycle).
  - Acceptance is independent of vid_req and blank.
  - The buffer captures cpu_addr/cpu_wdata at the edge.
  - Simultaneous drain and accept leaves wbuf_full=1 with the new contents.
- Ordering:
  - A CPU read is never acked while wbuf_full=1.
  - Writes therefore complete before any later read, so read-after-write to the same address returns the new data.
- Read latency is exactly 1 cycle:
  - vid_rvalid/cpu_rvalid are registered; each asserts the cycle after its grant.
  - vid_rdata and cpu_rdata pass mem_rdata through directly; they are meaningful only while the matching rvalid is high.
  - vid_rvalid and cpu_rvalid are never high together.
- cpu_ack is a one-cycle pulse per transaction. The requester may raise cpu_req for the next transaction in the cycle after cpu_ack.
- Stall counter:
  - Increments when cpu_req=1 & cpu_ack=0.
  - Saturates at all-ones.
  - stall_clr has priority over increment and zeroes the counter.
- Reset:
  - wbuf_full=0, vid_rvalid=0, cpu_rvalid=0, cpu_stall_cnt=0.
  - While reset=1: cpu_ack=0, mem_we=0, mem_addr=0; vid_req is ignored.
  - Reset mid-operation discards a pending buffered write (it is never written to RAM) and any in-flight read (no rvalid).
- ACTIVE_CPU=0 with blank=0: only video accesses occur, but writes may still be accepted into an empty buffer. The buffered write drains in the first cycle with blank=1 and vid_req=0.

Test Plan:
- Reset: pulse reset with cpu_req=1, cpu_we=1 -> cpu_ack=0, mem_we=0 throughout; after release wbuf_full=0 and cpu_stall_cnt=0.
- Video priority: ACTIVE_CPU=1, blank=0, vid_req=1 for 4 cycles on addrs 0x010..0x013, CPU read 0x200 pending -> 4 video grants, each vid_rvalid one cycle later; cpu_ack in cycle 5; cpu_rvalid in cycle 6; cpu_stall_cnt=4.
- Posted write: write 0x0A5=0x3C while vid_req=1 for 3 cycles -> cpu_ack in cycle 1 and wbuf_full=1; mem_we=1 with mem_addr=0x0A5, mem_wdata=0x3C in the first cycle with vid_req=0; then wbuf_full=0.
- Read-after-write: write 0x100=0x55, then read 0x100 with the buffer full -> read ack only after the drain cycle; cpu_rdata=0x55 with cpu_rvalid.
- Blank gating: ACTIVE_CPU=0, blank=0, CPU read 0x020, no vid_req for 10 cycles -> no ack; blank rises -> ack in that cycle, cpu_rvalid next; stall count=10.
- Reset mid-operation: buffered write 0x0FF=0xAA pending under vid_req; assert reset for 1 cycle -> mem_we never asserted for 0x0FF; wbuf_full=0 after reset.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle for the VRAM arbiter: video fetch port, CPU port and RAM port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vram_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_rvalid, vid_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM slot scheduler. Video reads own every slot they ask for;
// CPU writes are posted into a one-entry buffer and drained in free slots,
// CPU reads wait until the buffer is empty so read-after-write is coherent.
module vram_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 8,
  parameter bit ACTIVE_CPU = 1'b1,
  parameter int SW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          blank,
  vram_arbiter_if.slave bus,
  output logic          wbuf_full,
  input  logic          stall_clr,
  output logic [SW-1:0] cpu_stall_cnt
);

  logic          cpu_ok;
  logic          grant_vid;
  logic          grant_drain;
  logic          grant_rd;
  logic          accept_wr;
  logic [AW-1:0] wbuf_addr_p1;
  logic [DW-1:0] wbuf_data_p1;
  logic          vid_vld_p1;
  logic          cpu_vld_p1;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Slot arbitration: video first, then buffer drain, then CPU read; write posting runs alongside
  always_comb begin
    cpu_ok      = blank | ACTIVE_CPU;
    grant_vid   = 1'b0;
    grant_drain = 1'b0;
    grant_rd    = 1'b0;
    accept_wr   = 1'b0;
    if (!reset) begin
      if (bus.vid_req) begin
        grant_vid = 1'b1;
      end else if (wbuf_full && cpu_ok) begin
        grant_drain = 1'b1;
      end else if (!wbuf_full && cpu_ok && bus.cpu_req && !bus.cpu_we) begin
        grant_rd = 1'b1;
      end
      // A write may refill the buffer in the same cycle it drains
      accept_wr = bus.cpu_req && bus.cpu_we && (!wbuf_full || grant_drain);
    end
  end

  // RAM port steering and CPU acknowledge for the granted slot
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (grant_vid) begin
      bus.mem_addr = bus.vid_addr;
    end else if (grant_drain) begin
      bus.mem_addr  = wbuf_addr_p1;
      bus.mem_we    = 1'b1;
      bus.mem_wdata = wbuf_data_p1;
    end else if (grant_rd) begin
      bus.mem_addr = bus.cpu_addr;
    end
    bus.cpu_ack = grant_rd | accept_wr;
  end

  // ---- stage p1: write buffer occupancy ----
  // Occupancy flag; a reset discards any posted write
  always_ff @(posedge clk) begin
    if (reset) begin
      wbuf_full <= 1'b0;
    end else if (accept_wr) begin
      wbuf_full <= 1'b1;
    end else if (grant_drain) begin
      wbuf_full <= 1'b0;
    end
  end

  // Buffer payload capture; contents are only meaningful while wbuf_full is set
  always_ff @(posedge clk) begin
    if (accept_wr) begin
      wbuf_addr_p1 <= bus.cpu_addr;
      wbuf_data_p1 <= bus.cpu_wdata;
    end
  end

  // ---- stage p1: read return valids ----
  // Track which requester owns the RAM data returning next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      vid_vld_p1 <= 1'b0;
      cpu_vld_p1 <= 1'b0;
    end else begin
      vid_vld_p1 <= grant_vid;
      cpu_vld_p1 <= grant_rd;
    end
  end

  // Saturating count of cycles the CPU waited; clear wins over increment
  always_ff @(posedge clk) begin
    if (reset || stall_clr) begin
      cpu_stall_cnt <= '0;
    end else if (bus.cpu_req && !bus.cpu_ack) begin
      cpu_stall_cnt <= sat_inc(cpu_stall_cnt);
    end
  end

  // Read data is the RAM output passed straight through; a reset squashes in-flight returns
  assign bus.vid_rvalid = vid_vld_p1 & ~reset;
  assign bus.cpu_rvalid = cpu_vld_p1 & ~reset;
  assign bus.vid_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: two instances (CPU allowed during display, and
// CPU only in blanking with a narrow stall counter) share video/blank
// stimulus, each with its own CPU requester and behavioural RAM model.
module tb_vram_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int SW0 = 4;
  localparam int SW1 = 16;
  localparam int NW  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, blank, stall_clr;
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic          s_vid_req;
  logic [AW-1:0] s_vid_addr;
  logic          s_req [2];
  logic          s_we [2];
  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_wdata [2];

  logic           wbuf_full0, wbuf_full1;
  logic [SW0-1:0] cnt0;
  logic [SW1-1:0] cnt1;

  vram_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();
  vram_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  vram_arbiter #(.AW(AW), .DW(DW), .ACTIVE_CPU(1'b0), .SW(SW0)) u_dut0 (
    .clk(clk), .reset(rst), .blank(blank), .bus(bus0),
    .wbuf_full(wbuf_full0), .stall_clr(stall_clr), .cpu_stall_cnt(cnt0));

  vram_arbiter #(.AW(AW), .DW(DW), .ACTIVE_CPU(1'b1), .SW(SW1)) u_dut1 (
    .clk(clk), .reset(rst), .blank(blank), .bus(bus1),
    .wbuf_full(wbuf_full1), .stall_clr(stall_clr), .cpu_stall_cnt(cnt1));

  assign bus0.vid_req   = s_vid_req;
  assign bus0.vid_addr  = s_vid_addr;
  assign bus0.cpu_req   = s_req[0];
  assign bus0.cpu_we    = s_we[0];
  assign bus0.cpu_addr  = s_addr[0];
  assign bus0.cpu_wdata = s_wdata[0];
  assign bus1.vid_req   = s_vid_req;
  assign bus1.vid_addr  = s_vid_addr;
  assign bus1.cpu_req   = s_req[1];
  assign bus1.cpu_we    = s_we[1];
  assign bus1.cpu_addr  = s_addr[1];
  assign bus1.cpu_wdata = s_wdata[1];

  // Synchronous RAMs behind each arbiter, with a preload path
  logic [DW-1:0] ram0 [NW];
  logic [DW-1:0] ram1 [NW];
  logic [DW-1:0] rq0, rq1;
  always_ff @(posedge clk) begin
    if (pre_we) ram0[pre_addr] <= pre_data;
    else if (bus0.mem_we) ram0[bus0.mem_addr] <= bus0.mem_wdata;
    rq0 <= ram0[bus0.mem_addr];
  end
  always_ff @(posedge clk) begin
    if (pre_we) ram1[pre_addr] <= pre_data;
    else if (bus1.mem_we) ram1[bus1.mem_addr] <= bus1.mem_wdata;
    rq1 <= ram1[bus1.mem_addr];
  end
  assign bus0.mem_rdata = rq0;
  assign bus1.mem_rdata = rq1;

  // Output views indexed by instance
  logic          o_ack [2], o_mwe [2], o_vrv [2], o_crv [2], o_wbf [2];
  logic [AW-1:0] o_maddr [2];
  logic [DW-1:0] o_mwd [2], o_vrd [2], o_crd [2];
  logic [31:0]   o_cnt [2];
  assign o_ack[0] = bus0.cpu_ack;    assign o_ack[1] = bus1.cpu_ack;
  assign o_mwe[0] = bus0.mem_we;     assign o_mwe[1] = bus1.mem_we;
  assign o_vrv[0] = bus0.vid_rvalid; assign o_vrv[1] = bus1.vid_rvalid;
  assign o_crv[0] = bus0.cpu_rvalid; assign o_crv[1] = bus1.cpu_rvalid;
  assign o_wbf[0] = wbuf_full0;      assign o_wbf[1] = wbuf_full1;
  assign o_maddr[0] = bus0.mem_addr; assign o_maddr[1] = bus1.mem_addr;
  assign o_mwd[0] = bus0.mem_wdata;  assign o_mwd[1] = bus1.mem_wdata;
  assign o_vrd[0] = bus0.vid_rdata;  assign o_vrd[1] = bus1.vid_rdata;
  assign o_crd[0] = bus0.cpu_rdata;  assign o_crd[1] = bus1.cpu_rdata;
  assign o_cnt[0] = 32'(cnt0);       assign o_cnt[1] = 32'(cnt1);

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory contents, posted-write queue, pending returns
  logic [DW-1:0] shadow [2][NW];
  logic [AW-1:0] wq_addr [2][$];
  logic [DW-1:0] wq_data [2][$];
  bit            m_vp [2], m_cp [2], m_ack [2];
  logic [DW-1:0] m_vd [2], m_cd [2];
  int unsigned   m_cnt [2];
  int unsigned   cnt_max [2] = '{(1 << SW0) - 1, (1 << SW1) - 1};

  // Check one cycle against the model, advance the model, move to next negedge
  task automatic step();
    bit ok, gv, gd, gr, aw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    string t;
    #1;
    for (int k = 0; k < 2; k++) begin
      t  = $sformatf("%0d", k);
      ok = blank || (k == 1);
      gv = !rst && s_vid_req;
      gd = !rst && !gv && ok && (wq_addr[k].size() != 0);
      gr = !rst && !gv && ok && (wq_addr[k].size() == 0) && s_req[k] && !s_we[k];
      aw = !rst && s_req[k] && s_we[k] && ((wq_addr[k].size() == 0) || gd);
      ea = '0;
      ed = '0;
      if (gv) ea = s_vid_addr;
      else if (gd) begin ea = wq_addr[k][0]; ed = wq_data[k][0]; end
      else if (gr) ea = s_addr[k];
      check({"ack", t},   32'(o_ack[k]),   32'(gr || aw));
      check({"mwe", t},   32'(o_mwe[k]),   32'(gd));
      check({"maddr", t}, 32'(o_maddr[k]), 32'(ea));
      check({"mwd", t},   32'(o_mwd[k]),   32'(ed));
      check({"wbf", t},   32'(o_wbf[k]),   32'(wq_addr[k].size() != 0));
      check({"cnt", t},   o_cnt[k],        m_cnt[k]);
      check({"vrv", t},   32'(o_vrv[k]),   32'(m_vp[k] && !rst));
      check({"crv", t},   32'(o_crv[k]),   32'(m_cp[k] && !rst));
      if (m_vp[k] && !rst) check({"vrd", t}, 32'(o_vrd[k]), 32'(m_vd[k]));
      if (m_cp[k] && !rst) check({"crd", t}, 32'(o_crd[k]), 32'(m_cd[k]));
      // advance model to the next cycle
      m_vp[k] = gv;
      m_cp[k] = gr;
      if (gv) m_vd[k] = shadow[k][s_vid_addr];
      if (gr) m_cd[k] = shadow[k][s_addr[k]];
      if (gd) begin
        shadow[k][wq_addr[k][0]] = wq_data[k][0];
        void'(wq_addr[k].pop_front());
        void'(wq_data[k].pop_front());
      end
      if (aw) begin
        wq_addr[k].push_back(s_addr[k]);
        wq_data[k].push_back(s_wdata[k]);
      end
      if (rst) begin
        wq_addr[k].delete();
        wq_data[k].delete();
      end
      if (rst || stall_clr) m_cnt[k] = 0;
      else if (s_req[k] && !(gr || aw) && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      m_ack[k] = gr || aw;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) if (m_ack[k]) s_req[k] = 1'b0;
  endtask

  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    s_req[k] = 1'b1; s_we[k] = we; s_addr[k] = a; s_wdata[k] = d;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int blank_run;

  initial begin
    rst = 1'b1; blank = 1'b0; stall_clr = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    s_vid_req = 1'b0; s_vid_addr = '0;
    for (int k = 0; k < 2; k++) begin
      s_req[k] = 1'b0; s_we[k] = 1'b0; s_addr[k] = '0; s_wdata[k] = '0;
      m_vp[k] = 1'b0; m_cp[k] = 1'b0; m_ack[k] = 1'b0; m_cnt[k] = 0; m_vd[k] = '0; m_cd[k] = '0;
    end
    @(negedge clk);
    // preload both RAMs with identical random contents while in reset
    for (int i = 0; i < NW; i++) begin
      pre_we = 1'b1; pre_addr = AW'(i); pre_data = DW'($urandom);
      shadow[0][i] = pre_data; shadow[1][i] = pre_data;
      @(negedge clk);
    end
    pre_we = 1'b0;

    // reset held with a write pending: no ack, no RAM write
    set_req(0, 1'b1, 12'h123, 8'h77);
    set_req(1, 1'b1, 12'h123, 8'h77);
    steps(3);
    check("rst_wbf0", 32'(wbuf_full0), 32'd0);
    check("rst_wbf1", 32'(wbuf_full1), 32'd0);
    check("rst_cnt0", o_cnt[0], 32'd0);
    check("rst_cnt1", o_cnt[1], 32'd0);
    rst = 1'b0;
    step();
    blank = 1'b1;
    steps(2);

    // video priority over a pending CPU read
    blank = 1'b0; stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    set_req(0, 1'b0, 12'h200, 8'h00);
    set_req(1, 1'b0, 12'h200, 8'h00);
    for (int i = 0; i < 4; i++) begin
      s_vid_req = 1'b1; s_vid_addr = AW'(12'h010 + i);
      step();
    end
    s_vid_req = 1'b0;
    steps(2);
    check("vp_cnt1", o_cnt[1], 32'd4);
    blank = 1'b1;
    steps(2);

    // blank gating: read waits 10 cycles, acked when blank rises
    blank = 1'b0; stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    set_req(0, 1'b0, 12'h020, 8'h00);
    steps(10);
    check("bg_cnt0", o_cnt[0], 32'd10);
    blank = 1'b1;
    steps(2);

    // stall counter saturation on the narrow counter
    blank = 1'b0; stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    set_req(0, 1'b0, 12'h030, 8'h00);
    steps(20);
    check("sat_cnt0", o_cnt[0], 32'd15);
    blank = 1'b1;
    steps(2);

    // posted write under video, then read-after-write
    blank = 1'b0;
    set_req(1, 1'b1, 12'h0A5, 8'h3C);
    s_vid_req = 1'b1;
    for (int i = 0; i < 3; i++) begin s_vid_addr = AW'($urandom); step(); end
    s_vid_req = 1'b0;
    step();
    set_req(1, 1'b1, 12'h100, 8'h55);
    step();
    set_req(1, 1'b0, 12'h100, 8'h00);
    steps(4);
    check("raw_shadow", 32'(shadow[1][12'h100]), 32'h55);

    // reset discards a buffered write
    set_req(0, 1'b1, 12'h0FF, 8'hAA);
    set_req(1, 1'b1, 12'h0FF, 8'hAA);
    s_vid_req = 1'b1;
    steps(2);
    rst = 1'b1;
    step();
    check("mr_wbf0", 32'(wbuf_full0), 32'd0);
    check("mr_wbf1", 32'(wbuf_full1), 32'd0);
    rst = 1'b0; s_vid_req = 1'b0; blank = 1'b1;
    steps(3);

    // randomized traffic
    blank_run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (blank_run == 0) begin
        blank = ~blank;
        blank_run = $urandom_range(1, 40);
      end
      blank_run--;
      s_vid_req  = ($urandom_range(0, 1) == 0);
      s_vid_addr = AW'($urandom);
      rst        = ($urandom_range(0, 299) == 0);
      stall_clr  = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!s_req[k] && $urandom_range(0, 1) == 1)
          set_req(k, 1'($urandom), ($urandom_range(0, 3) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom),
                  DW'($urandom));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
